sdram_req_arbiter: RTL
======================

// Module: sdram_req_arbiter
// PURPOSE
//  Round-robin arbiter that shares the single valid/ready port of the SDRAM controller among NUM_PORTS requesters
//  (e.g. CPU, DMA, video fetch). Exactly one transaction is in flight at a time. Grant is held until the controller's
//  one-cycle ready pulse. The response is routed back to the granted requester only.
//  Sits between the bus masters and sys_sdram in the same clk domain.
// PARAMETERS
//  NUM_PORTS    4     number of requesters, 2..8
//  ADDR_W       32    address width
//  DATA_W       32    data width; STRB_W = DATA_W/8
//  TIMEOUT_CYC  1024  max BUSY cycles before err_timeout sets; 0 disables the watchdog
// PORTS
//  clk          in   1                  clock
//  rst_n        in   1                  synchronous reset, active-low
//  s_valid      in   NUM_PORTS          per-port request
//  s_addr       in   NUM_PORTS*ADDR_W   per-port address, port i at [i*ADDR_W +: ADDR_W]
//  s_wdata      in   NUM_PORTS*DATA_W   per-port write data
//  s_wstrb      in   NUM_PORTS*STRB_W   per-port byte strobes; all zero = read
//  s_ready      out  NUM_PORTS          one-hot, one-cycle completion pulse
//  s_rdata      out  DATA_W             read data, valid while s_ready[i]=1 (shared bus)
//  m_valid      out  1                  to controller i_valid
//  m_addr       out  ADDR_W             to controller i_addr
//  m_wdata      out  DATA_W             to controller i_wdata
//  m_wstrb      out  STRB_W             to controller i_wstrb
//  m_ready      in   1                  from controller o_ready (one-cycle pulse)
//  m_rdata      in   DATA_W             from controller o_rdata
//  grant_id     out  $clog2(NUM_PORTS)  index of current/last granted port
//  err_timeout  out  1                  sticky watchdog flag
// BEHAVIOUR
//  Reset (rst_n=0 at posedge):
//   - state=IDLE; m_valid=0; m_addr/m_wdata/m_wstrb=0; s_ready=0; s_rdata=0.
//   - grant_id=NUM_PORTS-1, so port 0 wins first. err_timeout=0; busy counter=0.
//  FSM states IDLE, BUSY, RELEASE:
//   - IDLE: if |s_valid, pick the first set bit searching (grant_id+1) mod NUM_PORTS upward with wrap.
//     Register that port's addr/wdata/wstrb into m_*, set grant_id, m_valid<=1, go BUSY.
//     m_valid is high 1 cycle after s_valid is first seen.
//   - BUSY: m_valid and m_* are held constant, with no re-arbitration. Busy counter increments.
//     On m_ready=1: m_valid<=0, s_ready[grant_id]<=1, s_rdata<=m_rdata (also captured for writes), go RELEASE.
//   - RELEASE: exactly 1 cycle; s_ready<=0; go IDLE. This gap lets the served requester drop s_valid,
//     so it is never double-issued.
//  Requester rules:
//   - hold s_valid until s_ready.
//   - payload is sampled only at grant; later changes are ignored.
//   - dropping s_valid while granted does not abort the request; the SDRAM op completes and s_ready still pulses.
//  Fairness:
//   - all ports requesting continuously -> grants rotate 0,1,..,N-1,0.
//   - worst-case wait is N-1 transactions.
//  Simultaneous events:
//   - m_ready in IDLE/RELEASE is ignored (spurious).
//   - new requests during BUSY are queued only by their s_valid level.
//  Watchdog:
//   - busy counter clears on entry to BUSY.
//   - when it reaches TIMEOUT_CYC, err_timeout<=1 (sticky until reset); the FSM keeps waiting.
//  Reset mid-transaction returns to IDLE immediately with all outputs at reset values. The controller shares
//  rst_n, so both restart together.
//  Widths: grant_id is $clog2(NUM_PORTS); wrap uses modulo NUM_PORTS for non-power-of-two counts.
// STRUCTURE
//  - Shared package sdram_pkg: SDRAM_ADDR_W=32, SDRAM_DATA_W=32, SDRAM_STRB_W=4, and the state encoding
//    localparams (ARB_IDLE=2'd0, ARB_BUSY=2'd1, ARB_RELEASE=2'd2).
//  - One sub-module, rr_pick: combinational round-robin priority picker (req vector + last grant -> index + any).
//    It is reusable by other arbiters.
//  - Payload mux and the FSM live in the top module.
// TESTING
//  1. Single read: port 2 valid, addr=0x0000_1230, wstrb=0.
//     -> m_valid 1 cycle later with m_addr=0x1230 and m_wstrb=0.
//     -> model returns m_ready with m_rdata=0xDEADBEEF -> s_ready=4'b0100 with s_rdata=0xDEADBEEF.
//     -> s_ready drops next cycle.
//  2. Round-robin: all 4 ports valid continuously, model acks after 6 cycles.
//     -> grant order 0,1,2,3,0,1; exactly one s_ready bit per ack.
//  3. Write payload: port 1 write wdata=0x11223344, wstrb=4'b0011; port 1 changes wdata to 0 during BUSY.
//     -> m_wdata stays 0x11223344 and m_wstrb stays 0011 until ack.
//  4. Spurious ack and no double-issue: m_ready pulsed in IDLE -> no s_ready.
//     Requester drops s_valid on its s_ready -> next m_valid serves a different port or none.
//  5. Watchdog: TIMEOUT_CYC=16, model never acks -> err_timeout=1 at BUSY cycle 16; m_valid still 1.
//     Then assert rst_n=0 -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared SDRAM interface widths and the request-arbiter state encoding.
package sdram_pkg;

  localparam int SDRAM_ADDR_W = 32;
  localparam int SDRAM_DATA_W = 32;
  localparam int SDRAM_STRB_W = 4;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_BUSY    = 2'd1,
    ARB_RELEASE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/sdram_req_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after the last grant, with wrap.
module rr_pick #(
  parameter  int N     = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_last,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  assign o_any = |i_req;

  // Walk from farthest to nearest candidate so the nearest set bit after i_last wins.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    o_idx = '0;
    for (int off = N; off >= 1; off--) begin
      int cand;
      cand = (int'(i_last) + off) % N;
      if (i_req[cand]) o_idx = IDX_W'(cand);
    end
  end

endmodule

// File: rtl/sdram_req_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller valid/ready port among NUM_PORTS requesters.
module sdram_req_arbiter
  import sdram_pkg::*;
#(
  parameter  int NUM_PORTS   = 4,
  parameter  int ADDR_W      = SDRAM_ADDR_W,
  parameter  int DATA_W      = SDRAM_DATA_W,
  parameter  int TIMEOUT_CYC = 1024,
  localparam int STRB_W      = DATA_W / 8,
  localparam int IDX_W       = $clog2(NUM_PORTS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_PORTS-1:0]          s_valid,
  input  logic [NUM_PORTS*ADDR_W-1:0]   s_addr,
  input  logic [NUM_PORTS*DATA_W-1:0]   s_wdata,
  input  logic [NUM_PORTS*STRB_W-1:0]   s_wstrb,
  output logic [NUM_PORTS-1:0]          s_ready,
  output logic [DATA_W-1:0]             s_rdata,
  output logic                          m_valid,
  output logic [ADDR_W-1:0]             m_addr,
  output logic [DATA_W-1:0]             m_wdata,
  output logic [STRB_W-1:0]             m_wstrb,
  input  logic                          m_ready,
  input  logic [DATA_W-1:0]             m_rdata,
  output logic [IDX_W-1:0]              grant_id,
  output logic                          err_timeout
);

  localparam int CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

  arb_state_e             r_state, w_state_nxt;
  logic [IDX_W-1:0]       r_grant;
  logic [CNT_W-1:0]       r_busy_cnt;
  logic                   r_err;
  logic                   r_m_valid;
  logic [ADDR_W-1:0]      r_m_addr;
  logic [DATA_W-1:0]      r_m_wdata;
  logic [STRB_W-1:0]      r_m_wstrb;
  logic [NUM_PORTS-1:0]   r_s_ready;
  logic [DATA_W-1:0]      r_s_rdata;

  logic [IDX_W-1:0]       w_pick_idx;
  logic                   w_pick_any;
  logic [ADDR_W-1:0]      w_sel_addr;
  logic [DATA_W-1:0]      w_sel_wdata;
  logic [STRB_W-1:0]      w_sel_wstrb;
  logic [NUM_PORTS-1:0]   w_grant_onehot;
  logic                   w_load, w_capture, w_release;

  rr_pick #(.N(NUM_PORTS)) u_rr_pick (
    .i_req  (s_valid),
    .i_last (r_grant),
    .o_idx  (w_pick_idx),
    .o_any  (w_pick_any)
  );

  // Payload mux for the picked port, plus one-hot decode of the held grant.
  always_comb begin
    w_sel_addr     = '0;
    w_sel_wdata    = '0;
    w_sel_wstrb    = '0;
    w_grant_onehot = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (w_pick_idx == IDX_W'(i)) begin
        w_sel_addr  = s_addr[i*ADDR_W +: ADDR_W];
        w_sel_wdata = s_wdata[i*DATA_W +: DATA_W];
        w_sel_wstrb = s_wstrb[i*STRB_W +: STRB_W];
      end
      w_grant_onehot[i] = (r_grant == IDX_W'(i));
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) r_state <= ARB_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ARB_IDLE:    if (w_pick_any) w_state_nxt = ARB_BUSY;
      ARB_BUSY:    if (m_ready)    w_state_nxt = ARB_RELEASE;
      ARB_RELEASE: w_state_nxt = ARB_IDLE;
      default:     w_state_nxt = ARB_IDLE;
    endcase
  end

  // FSM output decode; m_ready outside BUSY never reaches the datapath.
  always_comb begin
    w_load    = (r_state == ARB_IDLE) && w_pick_any;
    w_capture = (r_state == ARB_BUSY) && m_ready;
    w_release = (r_state == ARB_RELEASE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_grant    <= IDX_W'(NUM_PORTS - 1);
      r_busy_cnt <= '0;
      r_err      <= 1'b0;
      r_m_valid  <= 1'b0;
      r_m_addr   <= '0;
      r_m_wdata  <= '0;
      r_m_wstrb  <= '0;
      r_s_ready  <= '0;
      r_s_rdata  <= '0;
    end else begin
      if (w_load) begin
        r_grant    <= w_pick_idx;
        r_m_addr   <= w_sel_addr;
        r_m_wdata  <= w_sel_wdata;
        r_m_wstrb  <= w_sel_wstrb;
        r_m_valid  <= 1'b1;
        r_busy_cnt <= '0;
      end
      // Watchdog only flags the stall; the transaction keeps waiting for m_ready.
      if (r_state == ARB_BUSY && int'(r_busy_cnt) < TIMEOUT_CYC) begin
        r_busy_cnt <= r_busy_cnt + 1'b1;
        if (int'(r_busy_cnt) + 1 == TIMEOUT_CYC) r_err <= 1'b1;
      end
      if (w_capture) begin
        r_m_valid <= 1'b0;
        r_s_ready <= w_grant_onehot;
        r_s_rdata <= m_rdata;
      end
      if (w_release) r_s_ready <= '0;
    end
  end

  assign s_ready     = r_s_ready;
  assign s_rdata     = r_s_rdata;
  assign m_valid     = r_m_valid;
  assign m_addr      = r_m_addr;
  assign m_wdata     = r_m_wdata;
  assign m_wstrb     = r_m_wstrb;
  assign grant_id    = r_grant;
  assign err_timeout = r_err;

endmodule
